// File: rtl/pc_fetch_sequencer_if.sv
// Control-unit to fetch-sequencer bus: decoded flow strobes in, instruction address and mode out.
interface pc_fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              desvio;
    logic              type_jr;
    logic              taken;
    logic              halt;
    logic              syscall_sign;
    logic              pid_wr;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] reg_addr;
    logic              confirm;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_saved;
    logic              stall;
    logic              io_ack;
    logic              kernel_mode;
    logic              preempt;

    modport master (
        output desvio, type_jr, taken, halt, syscall_sign, pid_wr, jump_addr, reg_addr, confirm,
        input  pc, pc_saved, stall, io_ack, kernel_mode, preempt
    );

    modport slave (
        input  desvio, type_jr, taken, halt, syscall_sign, pid_wr, jump_addr, reg_addr, confirm,
        output pc, pc_saved, stall, io_ack, kernel_mode, preempt
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter / fetch sequencer with IN-wait handshake, syscall trap and kernel/user tracking.
// Optional time-slice preemption timer is enabled by defining PREEMPT_TIMER_EN.
module pc_fetch_sequencer #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned KERNEL_BASE = 0,
    parameter int unsigned QUANTUM     = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    pc_fetch_sequencer_if.slave bus
);
    typedef enum logic {RUN = 1'b0, WAIT_IO = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] PC_KERNEL = ADDR_W'(KERNEL_BASE);

    state_t            state;
    logic              conf_s1;
    logic              conf_s2;
    logic              conf_s3;
    logic              conf_rise_c;
    logic              take_c;
    logic              trap_c;
    logic [ADDR_W-1:0] pc_inc_c;
    logic [ADDR_W-1:0] flow_pc_c;

    assign conf_rise_c = conf_s2 & ~conf_s3;
    assign pc_inc_c    = bus.pc + ADDR_W'(1);
    assign take_c      = bus.desvio & (bus.type_jr | bus.taken);

    // Address the ordinary instruction flow would go to (JR beats taken branch beats fall-through).
    always_comb begin
        flow_pc_c = pc_inc_c;
        if (bus.desvio && bus.type_jr) begin
            flow_pc_c = bus.reg_addr;
        end else if (bus.desvio && bus.taken) begin
            flow_pc_c = bus.jump_addr;
        end
    end

`ifdef PREEMPT_TIMER_EN
    localparam int unsigned       CNT_W    = $clog2(QUANTUM + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(QUANTUM - 1);

    logic [CNT_W-1:0] slice_cnt;

    // Trap only on an eligible RUN cycle; otherwise the counter parks at CNT_LAST until one comes.
    assign trap_c = (state == RUN) && !bus.kernel_mode && (slice_cnt == CNT_LAST)
                    && !bus.syscall_sign && !bus.halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_cnt <= '0;
        end else if (state == RUN) begin
            if (bus.syscall_sign || bus.pid_wr || trap_c) begin
                slice_cnt <= '0;
            end else if (!bus.kernel_mode && (slice_cnt != CNT_LAST)) begin
                slice_cnt <= slice_cnt + CNT_W'(1);
            end
        end
    end
`else
    // No timer: never traps; the quantum stays referenced so the timer-less build carries no dangling parameter.
    assign trap_c = 1'b0 & (QUANTUM != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            conf_s1         <= 1'b0;
            conf_s2         <= 1'b0;
            conf_s3         <= 1'b0;
            bus.pc          <= PC_KERNEL;
            bus.pc_saved    <= '0;
            bus.stall       <= 1'b0;
            bus.io_ack      <= 1'b0;
            bus.kernel_mode <= 1'b1;
            bus.preempt     <= 1'b0;
        end else begin
            conf_s1     <= bus.confirm;
            conf_s2     <= conf_s1;
            conf_s3     <= conf_s2;
            bus.io_ack  <= 1'b0;
            bus.preempt <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.syscall_sign) begin
                        bus.pc          <= PC_KERNEL;
                        bus.pc_saved    <= pc_inc_c;
                        bus.kernel_mode <= 1'b1;
                    end else if (trap_c) begin
                        bus.pc          <= PC_KERNEL;
                        bus.pc_saved    <= flow_pc_c;
                        bus.kernel_mode <= 1'b1;
                        bus.preempt     <= 1'b1;
                    end else if (take_c) begin
                        bus.pc <= flow_pc_c;
                    end else if (bus.halt) begin
                        bus.stall <= 1'b1;
                        state     <= WAIT_IO;
                    end else begin
                        bus.pc <= pc_inc_c;
                    end
                    if (bus.pid_wr && !bus.syscall_sign && !trap_c) begin
                        bus.kernel_mode <= 1'b0;
                    end
                end
                WAIT_IO: begin
                    if (conf_rise_c) begin
                        bus.io_ack <= 1'b1;
                        bus.pc     <= pc_inc_c;
                        bus.stall  <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus a randomized run against a reference model.
module tb_pc_fetch_sequencer;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned KB     = 0;
    localparam int unsigned Q      = 4;
    localparam int          MOD    = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus();

    pc_fetch_sequencer #(
        .ADDR_W     (ADDR_W),
        .KERNEL_BASE(KB),
        .QUANTUM    (Q)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic d, input logic jr, input logic tk, input logic h,
                         input logic sy, input logic pd, input int ja, input int ra);
        bus.desvio       = d;
        bus.type_jr      = jr;
        bus.taken        = tk;
        bus.halt         = h;
        bus.syscall_sign = sy;
        bus.pid_wr       = pd;
        bus.jump_addr    = ADDR_W'(ja);
        bus.reg_addr     = ADDR_W'(ra);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic goto_pc(input int a);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 0);
        tick();
        idle();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle();
        bus.confirm = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.pc, bus.pc_saved, bus.stall, bus.io_ack, bus.kernel_mode, bus.preempt} !==
            {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0})
            begin errors++; $display("FAIL reset_values pc=%0d saved=%0d stall=%b ack=%b km=%b pre=%b expected 0 0 0 0 1 0",
                bus.pc, bus.pc_saved, bus.stall, bus.io_ack, bus.kernel_mode, bus.preempt); end
        repeat (3) tick();
        checks++;
        if (bus.pc !== 10'd3) begin errors++; $display("FAIL count3 pc=%0d expected 3", bus.pc); end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.pc, bus.kernel_mode, bus.stall} !== {10'd0, 1'b1, 1'b0})
            begin errors++; $display("FAIL async_reset pc=%0d km=%b stall=%b expected 0 1 0", bus.pc, bus.kernel_mode, bus.stall); end
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if ({bus.pc, bus.kernel_mode} !== {10'd5, 1'b1})
            begin errors++; $display("FAIL count5 pc=%0d km=%b expected 5 1", bus.pc, bus.kernel_mode); end
    endtask

    task automatic test_branch();
        goto_pc(8);
        checks++;
        if (bus.pc !== 10'd8) begin errors++; $display("FAIL goto8 pc=%0d expected 8", bus.pc); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40, 0);
        tick();
        checks++;
        if (bus.pc !== 10'd40) begin errors++; $display("FAIL branch_taken pc=%0d expected 40", bus.pc); end
        goto_pc(8);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 40, 0);
        tick();
        checks++;
        if (bus.pc !== 10'd9) begin errors++; $display("FAIL branch_not_taken pc=%0d expected 9", bus.pc); end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40, 100);
        tick();
        checks++;
        if (bus.pc !== 10'd100) begin errors++; $display("FAIL jr_untaken pc=%0d expected 100", bus.pc); end
        goto_pc(8);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 40, 100);
        tick();
        checks++;
        if (bus.pc !== 10'd100) begin errors++; $display("FAIL jr_taken pc=%0d expected 100", bus.pc); end
        idle();
    endtask

    task automatic test_halt_io();
        bit got;
        bus.confirm = 1'b1;
        repeat (3) tick();
        goto_pc(20);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        tick();
        checks++;
        if ({bus.pc, bus.stall, bus.io_ack} !== {10'd20, 1'b1, 1'b0})
            begin errors++; $display("FAIL halt_entry pc=%0d stall=%b ack=%b expected 20 1 0", bus.pc, bus.stall, bus.io_ack); end
        // Garbage strobes while waiting must be ignored; the held button must not count.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 500, 7);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.pc, bus.stall, bus.io_ack, bus.kernel_mode} !== {10'd20, 1'b1, 1'b0, 1'b1})
                begin errors++; $display("FAIL held_button cyc=%0d pc=%0d stall=%b ack=%b km=%b expected 20 1 0 1",
                    i, bus.pc, bus.stall, bus.io_ack, bus.kernel_mode); end
        end
        bus.confirm = 1'b0;
        repeat (3) tick();
        bus.confirm = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (bus.io_ack === 1'b1) got = 1'b1;
            else begin
                checks++;
                if ({bus.pc, bus.stall} !== {10'd20, 1'b1})
                    begin errors++; $display("FAIL wait_hold pc=%0d stall=%b expected 20 1", bus.pc, bus.stall); end
            end
        end
        idle();
        checks++;
        if (!got) begin errors++; $display("FAIL io_ack_timeout ack=%b expected 1 within 8 cycles", bus.io_ack); end
        checks++;
        if ({bus.pc, bus.stall} !== {10'd21, 1'b0})
            begin errors++; $display("FAIL after_ack pc=%0d stall=%b expected 21 0", bus.pc, bus.stall); end
        tick();
        checks++;
        if ({bus.pc, bus.io_ack} !== {10'd22, 1'b0})
            begin errors++; $display("FAIL ack_pulse pc=%0d ack=%b expected 22 0", bus.pc, bus.io_ack); end
        bus.confirm = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_syscall();
        goto_pc(300);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 77, 0);
        tick();
        idle();
        checks++;
        if ({bus.pc, bus.pc_saved, bus.kernel_mode} !== {10'(KB), 10'd301, 1'b1})
            begin errors++; $display("FAIL syscall pc=%0d saved=%0d km=%b expected %0d 301 1", bus.pc, bus.pc_saved, bus.kernel_mode, KB); end
    endtask

    task automatic test_wrap();
        goto_pc(1023);
        tick();
        checks++;
        if (bus.pc !== 10'd0) begin errors++; $display("FAIL pc_wrap pc=%0d expected 0", bus.pc); end
        goto_pc(1023);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        tick();
        checks++;
        if (bus.pc_saved !== 10'd0) begin errors++; $display("FAIL saved_wrap saved=%0d expected 0", bus.pc_saved); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        tick();
        checks++;
        if ({bus.kernel_mode, bus.pc} !== {1'b0, 10'd1})
            begin errors++; $display("FAIL pid_user km=%b pc=%0d expected 0 1", bus.kernel_mode, bus.pc); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        tick();
        idle();
        checks++;
        if ({bus.kernel_mode, bus.pc_saved} !== {1'b1, 10'd2})
            begin errors++; $display("FAIL pid_vs_syscall km=%b saved=%0d expected 1 2", bus.kernel_mode, bus.pc_saved); end
    endtask

`ifdef PREEMPT_TIMER_EN
    task automatic test_preempt();
        bit got;
        goto_pc(49);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.pc, bus.preempt, bus.kernel_mode} !== {10'(51 + i), 1'b0, 1'b0})
                begin errors++; $display("FAIL slice_run pc=%0d pre=%b km=%b expected %0d 0 0", bus.pc, bus.preempt, bus.kernel_mode, 51 + i); end
        end
        tick();
        checks++;
        if ({bus.pc, bus.pc_saved, bus.kernel_mode, bus.preempt} !== {10'(KB), 10'd54, 1'b1, 1'b1})
            begin errors++; $display("FAIL preempt_trap pc=%0d saved=%0d km=%b pre=%b expected %0d 54 1 1",
                bus.pc, bus.pc_saved, bus.kernel_mode, bus.preempt, KB); end
        tick();
        checks++;
        if (bus.preempt !== 1'b0) begin errors++; $display("FAIL preempt_pulse pre=%b expected 0", bus.preempt); end

        goto_pc(49);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        tick();
        idle();
        repeat (3) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        tick();
        idle();
        checks++;
        if ({bus.pc, bus.stall, bus.preempt} !== {10'd53, 1'b1, 1'b0})
            begin errors++; $display("FAIL deferred_halt pc=%0d stall=%b pre=%b expected 53 1 0", bus.pc, bus.stall, bus.preempt); end
        bus.confirm = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (bus.io_ack === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL deferred_ack_timeout ack=%b expected 1 within 8 cycles", bus.io_ack); end
        checks++;
        if ({bus.pc, bus.kernel_mode, bus.preempt} !== {10'd54, 1'b0, 1'b0})
            begin errors++; $display("FAIL deferred_ack pc=%0d km=%b pre=%b expected 54 0 0", bus.pc, bus.kernel_mode, bus.preempt); end
        tick();
        checks++;
        if ({bus.pc, bus.pc_saved, bus.kernel_mode, bus.preempt} !== {10'(KB), 10'd55, 1'b1, 1'b1})
            begin errors++; $display("FAIL deferred_trap pc=%0d saved=%0d km=%b pre=%b expected %0d 55 1 1",
                bus.pc, bus.pc_saved, bus.kernel_mode, bus.preempt, KB); end
        bus.confirm = 1'b0;
        repeat (3) tick();
    endtask
`endif

    // Reference model: architectural PC/mode rules, with the button seen two edges late through the synchroniser.
    task automatic test_random();
        int  m_pc, m_saved, flow, ja, ra;
        bit  m_km, m_wait, m_ack, m_pre, trap;
        bit  h1, h2, h3, rise, c;
        bit  d, jr, tk, hl, sy, pd;
`ifdef PREEMPT_TIMER_EN
        int  m_cnt;
`endif
        apply_reset();
        m_pc = int'(KB); m_saved = 0; m_km = 1'b1; m_wait = 1'b0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; c = 1'b0;
`ifdef PREEMPT_TIMER_EN
        m_cnt = 0;
`endif
        for (int n = 0; n < 400; n++) begin
            d  = ($urandom_range(0, 2) == 0);
            jr = 1'($urandom_range(0, 1));
            tk = 1'($urandom_range(0, 1));
            hl = ($urandom_range(0, 7) == 0);
            sy = ($urandom_range(0, 15) == 0);
            pd = ($urandom_range(0, 7) == 0);
            ja = int'($urandom_range(0, MOD - 1));
            ra = int'($urandom_range(0, MOD - 1));
            if ($urandom_range(0, 2) == 0) c = !c;
            drive(d, jr, tk, hl, sy, pd, ja, ra);
            bus.confirm = c;
            rise = h2 && !h3;
            h3 = h2; h2 = h1; h1 = c;
            m_ack = 1'b0;
            m_pre = 1'b0;
            if (m_wait) begin
                if (rise) begin
                    m_ack = 1'b1;
                    m_wait = 1'b0;
                    m_pc = (m_pc + 1) % MOD;
                end
            end else begin
                flow = (d && jr) ? ra : (d && tk) ? ja : (m_pc + 1) % MOD;
                trap = 1'b0;
`ifdef PREEMPT_TIMER_EN
                trap = !m_km && (m_cnt >= int'(Q) - 1) && !sy && !hl;
                if (sy || pd || trap) m_cnt = 0;
                else if (!m_km && m_cnt < int'(Q) - 1) m_cnt++;
`endif
                if (sy) begin
                    m_saved = (m_pc + 1) % MOD; m_pc = int'(KB); m_km = 1'b1;
                end else if (trap) begin
                    m_saved = flow; m_pc = int'(KB); m_km = 1'b1; m_pre = 1'b1;
                end else if (d && (jr || tk)) begin
                    m_pc = flow;
                end else if (hl) begin
                    m_wait = 1'b1;
                end else begin
                    m_pc = (m_pc + 1) % MOD;
                end
                if (pd && !sy && !trap) m_km = 1'b0;
            end
            tick();
            checks++;
            if ({bus.pc, bus.pc_saved, bus.stall, bus.io_ack, bus.kernel_mode, bus.preempt} !==
                {ADDR_W'(m_pc), ADDR_W'(m_saved), m_wait, m_ack, m_km, m_pre})
                begin errors++; $display("FAIL random cyc=%0d got pc=%0d saved=%0d st=%b ack=%b km=%b pre=%b expected pc=%0d saved=%0d st=%b ack=%b km=%b pre=%b",
                    n, bus.pc, bus.pc_saved, bus.stall, bus.io_ack, bus.kernel_mode, bus.preempt,
                    m_pc, m_saved, m_wait, m_ack, m_km, m_pre); end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_branch();
        test_halt_io();
        test_syscall();
        test_wrap();
`ifdef PREEMPT_TIMER_EN
        test_preempt();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
